// File: rtl/math_pkg.sv
// math_pkg: shared types and constants for the math datapath blocks
package math_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_e;

    localparam int SqrtMinDw = 4;

endpackage

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative restoring integer square root, one root bit per cycle; MATH_SQRT_ROUND_EN selects round-to-nearest root
module sqrt_iter
    import math_pkg::*;
#(
    parameter  int InDw   = 8,
    localparam int RootDw = InDw / 2,
    localparam int CntDw  = $clog2(RootDw + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tc_mode_i,
    input  logic              en_pi,
    input  logic [InDw-1:0]   a_i,
    output logic              busy_o,
    output logic              invalid_o,
    output logic              root_valid_o,
    output logic [RootDw-1:0] root_o,
    output logic [RootDw:0]   rem_o
);

    if ((InDw % 2) != 0 || InDw < SqrtMinDw) begin : g_param_chk
        $error("sqrt_iter: InDw must be even and at least %0d", SqrtMinDw);
    end

    sqrt_state_e       state_q, state_d;
    logic [InDw-1:0]   d_q;
    logic [RootDw+1:0] r_q;
    logic [RootDw-1:0] q_q;
    logic [CntDw-1:0]  cnt_q;
    logic              neg_q;
    logic              a_neg;
    logic              last;
    logic [RootDw+2:0] step;
    logic [RootDw-1:0] root_res;

    // One restoring step: try subtracting {Q,01}; the MSB of the trial is its sign.
    // R never exceeds 2Q, so its top bit can be dropped when shifting in the next pair.
    function automatic logic [RootDw+2:0] sqrt_step(input logic [RootDw+1:0] r,
                                                    input logic [RootDw-1:0] q,
                                                    input logic [1:0] d2);
        logic [RootDw+2:0] rt;
        logic [RootDw+2:0] t;
        rt = {r[RootDw:0], d2};
        t  = rt - {1'b0, q, 2'b01};
        return t[RootDw+2] ? {rt[RootDw+1:0], 1'b0} : {t[RootDw+1:0], 1'b1};
    endfunction

    assign a_neg  = tc_mode_i & a_i[InDw-1];
    assign last   = cnt_q == CntDw'(RootDw - 1);
    assign step   = sqrt_step(r_q, q_q, d_q[InDw-1:InDw-2]);
    assign busy_o = state_q != IDLE;

`ifdef MATH_SQRT_ROUND_EN
    // Round to nearest: bump the floor root when the remainder exceeds it, saturating at all ones.
    always_comb root_res = (r_q > {2'b00, q_q} && !(&q_q)) ? q_q + RootDw'(1) : q_q;
`else
    // Truncated floor root.
    always_comb root_res = q_q;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: fixed RootDw CALC cycles, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = en_pi ? CALC : IDLE;
            CALC:    state_d = last ? DONE : CALC;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers; the valid pulse lines up with DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q          <= '0;
            r_q          <= '0;
            q_q          <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            invalid_o    <= 1'b0;
            root_valid_o <= 1'b0;
            root_o       <= '0;
            rem_o        <= '0;
        end else begin
            root_valid_o <= 1'b0;
            if (state_q == IDLE && en_pi) begin
                d_q   <= a_neg ? '0 : a_i;
                r_q   <= '0;
                q_q   <= '0;
                cnt_q <= '0;
                neg_q <= a_neg;
            end else if (state_q == CALC) begin
                r_q   <= step[RootDw+2:1];
                q_q   <= {q_q[RootDw-2:0], step[0]};
                d_q   <= d_q << 2;
                cnt_q <= cnt_q + CntDw'(1);
                if (last) begin
                    root_valid_o <= 1'b1;
                    invalid_o    <= neg_q;
                end
            end else if (state_q == DONE) begin
                root_o <= neg_q ? '1 : root_res;
                rem_o  <= neg_q ? '0 : r_q[RootDw:0];
            end
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed self-checking bench for sqrt_iter with InDw=8
module tb_sqrt_iter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tc_mode_i;
    logic       en_pi;
    logic [7:0] a_i;
    logic       busy_o;
    logic       invalid_o;
    logic       root_valid_o;
    logic [3:0] root_o;
    logic [4:0] rem_o;

    int checks = 0;
    int errors = 0;
    int pulses;

    sqrt_iter #(.InDw(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tc_mode_i   (tc_mode_i),
        .en_pi       (en_pi),
        .a_i         (a_i),
        .busy_o      (busy_o),
        .invalid_o   (invalid_o),
        .root_valid_o(root_valid_o),
        .root_o      (root_o),
        .rem_o       (rem_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start in the current cycle (cycle 0), check busy/valid timing through cycle 5, results in cycle 6.
    task automatic run(input string tag, input logic tc, input logic [7:0] a,
                       input logic [3:0] er, input logic [4:0] em, input logic ei);
        tc_mode_i = tc;
        a_i       = a;
        en_pi     = 1'b1;
        tick();
        en_pi     = 1'b0;
        a_i       = 8'h00;
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "_busy"}, busy_o, 1'b1);
            chk({tag, "_valid"}, root_valid_o, c == 5);
            if (c == 5) chk({tag, "_inv5"}, invalid_o, ei);
            if (c < 5) tick();
        end
        tick();
        chk({tag, "_busy6"}, busy_o, 1'b0);
        chk({tag, "_valid6"}, root_valid_o, 1'b0);
        chk({tag, "_root"}, root_o, er);
        chk({tag, "_rem"}, rem_o, em);
        chk({tag, "_inv"}, invalid_o, ei);
    endtask

    initial begin
        rst_ni    = 1'b0;
        tc_mode_i = 1'b0;
        en_pi     = 1'b0;
        a_i       = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", root_valid_o, 1'b0);
        chk("rst_root", root_o, 4'h0);
        chk("rst_rem", rem_o, 5'h00);
        chk("rst_inv", invalid_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        run("a144", 1'b0, 8'h90, 4'd12, 5'd0, 1'b0);
        run("a255", 1'b0, 8'hFF, 4'd15, 5'd30, 1'b0);
`ifdef MATH_SQRT_ROUND_EN
        run("a99", 1'b0, 8'd99, 4'd10, 5'd18, 1'b0);
`else
        run("a99", 1'b0, 8'd99, 4'd9, 5'd18, 1'b0);
`endif
        run("neg80", 1'b1, 8'h80, 4'hF, 5'd0, 1'b1);
        run("s49", 1'b1, 8'h31, 4'd7, 5'd0, 1'b0);

        // Second start while busy must be ignored.
        pulses    = 0;
        tc_mode_i = 1'b0;
        a_i       = 8'hFF;
        en_pi     = 1'b1;
        tick();
        en_pi = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin
                a_i   = 8'h04;
                en_pi = 1'b1;
            end
            if (c == 3) en_pi = 1'b0;
            if (root_valid_o) pulses++;
            if (c < 6) tick();
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_busy6", busy_o, 1'b0);
        chk("ign_root", root_o, 4'd15);
        chk("ign_rem", rem_o, 5'd30);
        run("a4", 1'b0, 8'h04, 4'd2, 5'd0, 1'b0);

        // Asynchronous reset in the middle of CALC.
        a_i   = 8'h90;
        en_pi = 1'b1;
        tick();
        en_pi = 1'b0;
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_valid", root_valid_o, 1'b0);
        chk("arst_root", root_o, 4'h0);
        chk("arst_rem", rem_o, 5'h00);
        chk("arst_inv", invalid_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (root_valid_o) pulses++;
        end
        chk("arst_nopulse", pulses, 0);
        run("a0", 1'b0, 8'h00, 4'd0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
